// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. It issues one request at a time on the instruction
//   bus and places each returned word in a registered fetch-to-decode slot (fd_*).
//   A one-entry buffer holds a word that arrives while decode is stalled.
//   Redirects from execute take priority over everything else. A redirect that
//   arrives while a request is still in flight waits in FLUSH. FLUSH absorbs
//   the stale response before fetch resumes at the new target.
//
// Ports
//   clk             in   1   clock, rising edge
//   reset           in   1   asynchronous, active-low reset
//   ireq_valid      out  1   instruction-bus request valid
//   ireq_addr       out  64  instruction-bus request address
//   iresp_data_ok   in   1   response valid, completes the outstanding request
//   iresp_data      in   32  returned instruction word
//   redirect_valid  in   1   branch/jump redirect
//   redirect_pc     in   64  redirect target
//   stall           in   1   decode cannot accept a new instruction
//   fd_valid        out  1   fetch-to-decode slot holds an instruction
//   fd_raw_instr    out  32  instruction in the slot
//   fd_pc           out  64  PC of fd_raw_instr
//   fd_misalign     out  1   (FETCH_MISALIGN_EN only) slot holds a misaligned-PC marker
//
// Configuration
//   FETCH_MISALIGN_EN  When defined, fetch does not request a misaligned PC
//                      (pc[1:0] != 0). It places a marker entry {1, 0, pc} with
//                      fd_misalign=1 in the slot and halts until the next
//                      redirect. When undefined, the two low address bits
//                      are forced to zero.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        fd_valid,
  output logic [31:0] fd_raw_instr,
  output logic [63:0] fd_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fd_misalign
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      r_state,     w_state_nxt;
  logic [63:0] r_pc,        w_pc_nxt;
  logic [63:0] r_target,    w_target_nxt;
  logic        r_fd_valid,  w_fd_valid_nxt;
  logic [31:0] r_fd_instr,  w_fd_instr_nxt;
  logic [63:0] r_fd_pc,     w_fd_pc_nxt;
  logic        r_buf_valid, w_buf_valid_nxt;
  logic [31:0] r_buf_instr, w_buf_instr_nxt;
  logic [63:0] r_buf_pc,    w_buf_pc_nxt;

  // The slot can take a new word when it is empty or when decode consumes it this cycle.
  logic        w_fd_accept;
  logic [63:0] w_pc_inc;
  assign w_fd_accept = !r_fd_valid || !stall;
  assign w_pc_inc    = r_pc + 64'd4;

`ifdef FETCH_MISALIGN_EN
  logic r_halt,     w_halt_nxt;
  logic r_misalign, w_misalign_nxt;
  logic w_no_req;
  // A request is outstanding in FETCH only for an aligned PC. It is never outstanding after a halt.
  assign w_no_req    = r_halt || (r_pc[1:0] != 2'b00);
  assign ireq_valid  = (r_state != S_HOLD) && !w_no_req;
  assign ireq_addr   = r_pc;
  assign fd_misalign = r_misalign;
`else
  assign ireq_valid  = (r_state != S_HOLD);
  assign ireq_addr   = {r_pc[63:2], 2'b00};
`endif

  assign fd_valid     = r_fd_valid;
  assign fd_raw_instr = r_fd_instr;
  assign fd_pc        = r_fd_pc;

  // NOTE: every next-state variable gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_target_nxt    = r_target;
    w_fd_valid_nxt  = r_fd_valid;
    w_fd_instr_nxt  = r_fd_instr;
    w_fd_pc_nxt     = r_fd_pc;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_instr_nxt = r_buf_instr;
    w_buf_pc_nxt    = r_buf_pc;
`ifdef FETCH_MISALIGN_EN
    w_halt_nxt      = r_halt;
    w_misalign_nxt  = r_misalign;
`endif

    // Decode consumes the slot when it is not stalled. A load below overrides this.
    if (!stall) w_fd_valid_nxt = 1'b0;

    case (r_state)
      S_FETCH: begin
`ifdef FETCH_MISALIGN_EN
        if (w_no_req) begin
          // No request is in flight, so a redirect restarts fetch directly.
          if (redirect_valid) begin
            w_fd_valid_nxt = 1'b0;
            w_pc_nxt       = redirect_pc;
            w_halt_nxt     = 1'b0;
          end else if (!r_halt && w_fd_accept) begin
            w_fd_valid_nxt = 1'b1;
            w_fd_instr_nxt = 32'h0;
            w_fd_pc_nxt    = r_pc;
            w_misalign_nxt = 1'b1;
            w_halt_nxt     = 1'b1;
          end
        end else
`endif
        if (redirect_valid) begin
          w_fd_valid_nxt = 1'b0;
          if (iresp_data_ok) begin
            w_pc_nxt = redirect_pc;
          end else begin
            // The in-flight response still has to be absorbed.
            w_target_nxt = redirect_pc;
            w_state_nxt  = S_FLUSH;
          end
        end else if (iresp_data_ok) begin
          w_pc_nxt = w_pc_inc;
          if (w_fd_accept) begin
            w_fd_valid_nxt = 1'b1;
            w_fd_instr_nxt = iresp_data;
            w_fd_pc_nxt    = r_pc;
`ifdef FETCH_MISALIGN_EN
            w_misalign_nxt = 1'b0;
`endif
          end else begin
            w_buf_valid_nxt = 1'b1;
            w_buf_instr_nxt = iresp_data;
            w_buf_pc_nxt    = r_pc;
            w_state_nxt     = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          w_fd_valid_nxt  = 1'b0;
          w_buf_valid_nxt = 1'b0;
          w_pc_nxt        = redirect_pc;
          w_state_nxt     = S_FETCH;
        end else if (!stall) begin
          w_fd_valid_nxt  = 1'b1;
          w_fd_instr_nxt  = r_buf_instr;
          w_fd_pc_nxt     = r_buf_pc;
          w_buf_valid_nxt = 1'b0;
          w_state_nxt     = S_FETCH;
`ifdef FETCH_MISALIGN_EN
          w_misalign_nxt  = 1'b0;
`endif
        end
      end

      S_FLUSH: begin
        if (redirect_valid) begin
          w_fd_valid_nxt = 1'b0;
          if (iresp_data_ok) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = S_FETCH;
          end else begin
            w_target_nxt = redirect_pc;
          end
        end else if (iresp_data_ok) begin
          w_pc_nxt    = r_target;
          w_state_nxt = S_FETCH;
        end
      end

      default: w_state_nxt = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_FETCH;
      r_pc        <= PCINIT;
      r_target    <= 64'h0;
      r_fd_valid  <= 1'b0;
      r_fd_instr  <= 32'h0;
      r_fd_pc     <= 64'h0;
      r_buf_valid <= 1'b0;
      r_buf_instr <= 32'h0;
      r_buf_pc    <= 64'h0;
`ifdef FETCH_MISALIGN_EN
      r_halt      <= 1'b0;
      r_misalign  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_target    <= w_target_nxt;
      r_fd_valid  <= w_fd_valid_nxt;
      r_fd_instr  <= w_fd_instr_nxt;
      r_fd_pc     <= w_fd_pc_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_instr <= w_buf_instr_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
`ifdef FETCH_MISALIGN_EN
      r_halt      <= w_halt_nxt;
      r_misalign  <= w_misalign_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed testbench for fetch_unit. Inputs change 2 ns after each rising
//   edge. Outputs are checked at the same point, well away from the edge.
//   All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        fd_valid;
  logic [31:0] fd_raw_instr;
  logic [63:0] fd_pc;
`ifdef FETCH_MISALIGN_EN
  logic        fd_misalign;
`endif

  int n_checks;
  int n_errors;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .fd_valid       (fd_valid),
    .fd_raw_instr   (fd_raw_instr),
    .fd_pc          (fd_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .fd_misalign    (fd_misalign)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    stall          = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_fd_valid", 64'(fd_valid), 64'd0);
    check("rst_fd_instr", 64'(fd_raw_instr), 64'd0);
    check("rst_fd_pc", fd_pc, 64'd0);

    // Reset release: first request at PCINIT, one-cycle latency to fd_*
    reset = 1'b1;
    check("rel_req_valid", 64'(ireq_valid), 64'd1);
    check("rel_req_addr", ireq_addr, 64'h0000_0000_8000_0000);
    iresp_data_ok = 1'b1; iresp_data = 32'h0010_0093;
    tick();
    check("first_fd_valid", 64'(fd_valid), 64'd1);
    check("first_fd_instr", 64'(fd_raw_instr), 64'h0010_0093);
    check("first_fd_pc", fd_pc, 64'h8000_0000);
    check("first_next_addr", ireq_addr, 64'h8000_0004);

    // Stall with full slot: word buffered, HOLD, slot unchanged
    stall = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0020_8133;
    tick();
    check("hold_req_valid", 64'(ireq_valid), 64'd0);
    check("hold_fd_valid", 64'(fd_valid), 64'd1);
    check("hold_fd_instr", 64'(fd_raw_instr), 64'h0010_0093);
    check("hold_fd_pc", fd_pc, 64'h8000_0000);
    iresp_data_ok = 1'b0; stall = 1'b0;
    tick();
    check("unhold_fd_instr", 64'(fd_raw_instr), 64'h0020_8133);
    check("unhold_fd_pc", fd_pc, 64'h8000_0004);
    check("unhold_req_valid", 64'(ireq_valid), 64'd1);
    check("unhold_req_addr", ireq_addr, 64'h8000_0008);

    // No new word and no stall: slot drains
    tick();
    check("drain_fd_valid", 64'(fd_valid), 64'd0);

    // Redirect while waiting, response two cycles later is discarded
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    check("flush_fd_valid", 64'(fd_valid), 64'd0);
    check("flush_req_valid", 64'(ireq_valid), 64'd1);
    check("flush_addr_stable", ireq_addr, 64'h8000_0008);
    tick();
    iresp_data_ok = 1'b1; iresp_data = 32'hdead_beef;
    tick();
    iresp_data_ok = 1'b0;
    check("flush_done_fd_valid", 64'(fd_valid), 64'd0);
    check("flush_done_addr", ireq_addr, 64'h8000_0100);

    // Redirect coinciding with a response: word dropped
    iresp_data_ok = 1'b1; iresp_data = 32'h1111_1111;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    tick();
    iresp_data_ok = 1'b0; redirect_valid = 1'b0;
    check("coinc_fd_valid", 64'(fd_valid), 64'd0);
    check("coinc_addr", ireq_addr, 64'h8000_0200);

    // Normal fetch at the redirect target
    iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013;
    tick();
    check("tgt_fd_instr", 64'(fd_raw_instr), 64'h0000_0013);
    check("tgt_fd_pc", fd_pc, 64'h8000_0200);
    check("tgt_next_addr", ireq_addr, 64'h8000_0204);

    // Redirect in HOLD beats the stall and drops the buffered word
    stall = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h2222_2222;
    tick();
    iresp_data_ok = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    check("hold_redir_fd_valid", 64'(fd_valid), 64'd0);
    check("hold_redir_req_valid", 64'(ireq_valid), 64'd1);
    check("hold_redir_addr", ireq_addr, 64'h8000_0300);

    // A second redirect in FLUSH overwrites the saved target
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
    tick();
    redirect_pc = 64'h8000_0500;
    tick();
    redirect_valid = 1'b0;
    check("flush2_addr_stable", ireq_addr, 64'h8000_0300);
    iresp_data_ok = 1'b1; iresp_data = 32'h3333_3333;
    tick();
    iresp_data_ok = 1'b0;
    check("flush2_fd_valid", 64'(fd_valid), 64'd0);
    check("flush2_addr", ireq_addr, 64'h8000_0500);

    // PC increment wraps at the top of the 64-bit space
    iresp_data_ok = 1'b1; iresp_data = 32'h0;
    redirect_valid = 1'b1; redirect_pc = 64'hffff_ffff_ffff_fffc;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr_top", ireq_addr, 64'hffff_ffff_ffff_fffc);
    iresp_data_ok = 1'b1; iresp_data = 32'h4444_4444;
    tick();
    iresp_data_ok = 1'b0;
    check("wrap_fd_pc", fd_pc, 64'hffff_ffff_ffff_fffc);
    check("wrap_fd_instr", 64'(fd_raw_instr), 64'h4444_4444);
    check("wrap_addr_zero", ireq_addr, 64'h0);

    // Asynchronous reset between clock edges, mid-request
    #2;
    reset = 1'b0;
    #1;
    check("areset_fd_valid", 64'(fd_valid), 64'd0);
    check("areset_fd_instr", 64'(fd_raw_instr), 64'd0);
    check("areset_fd_pc", fd_pc, 64'd0);
    check("areset_addr", ireq_addr, 64'h8000_0000);
    iresp_data_ok = 1'b1; iresp_data = 32'h5555_5555;
    tick();
    tick();
    iresp_data_ok = 1'b0;
    reset = 1'b1;
    check("rerel_fd_valid", 64'(fd_valid), 64'd0);
    check("rerel_addr", ireq_addr, 64'h8000_0000);
    iresp_data_ok = 1'b1; iresp_data = 32'h0010_0093;
    tick();
    iresp_data_ok = 1'b0;
    check("rerel_fd_instr", 64'(fd_raw_instr), 64'h0010_0093);
    check("rerel_fd_pc", fd_pc, 64'h8000_0000);

`ifdef FETCH_MISALIGN_EN
    // Misaligned redirect: no request, marker entry, fetch halted
    iresp_data_ok = 1'b1; iresp_data = 32'h6666_6666;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
    tick();
    iresp_data_ok = 1'b0; redirect_valid = 1'b0;
    check("mis_req_valid", 64'(ireq_valid), 64'd0);
    tick();
    check("mis_fd_valid", 64'(fd_valid), 64'd1);
    check("mis_flag", 64'(fd_misalign), 64'd1);
    check("mis_fd_pc", fd_pc, 64'h8000_0102);
    check("mis_fd_instr", 64'(fd_raw_instr), 64'd0);
    tick();
    check("mis_halted", 64'(ireq_valid), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PCINIT, default 64'h0000_0000_8000_0000, the PC fetched first after reset.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port ireq_valid  out  1  instruction-bus request valid.
REQ-005 SHALL have port ireq_addr  out  64  instruction-bus request address.
REQ-006 SHALL have port iresp_data_ok  in  1  instruction-bus response valid; completes the outstanding request.
REQ-007 SHALL have port iresp_data  in  32  returned instruction word, meaningful only with iresp_data_ok.
REQ-008 SHALL have port redirect_valid  in  1  branch/jump redirect from execute.
REQ-009 SHALL have port redirect_pc  in  64  redirect target.
REQ-010 SHALL have port stall  in  1  decode cannot accept a new instruction this cycle.
REQ-011 SHALL have port fd_valid  out  1  registered fetch-to-decode slot holds an instruction.
REQ-012 SHALL have port fd_raw_instr  out  32  registered instruction, feeds decode control unit raw_instr.
REQ-013 SHALL have port fd_pc  out  64  registered PC of fd_raw_instr.

Function
REQ-014 SHALL implement three states: FETCH (request issued), HOLD (response buffered, bus idle), FLUSH (outstanding response to discard).
REQ-015 SHALL drive ireq_valid=1 in FETCH and FLUSH, and 0 in HOLD.
REQ-016 SHALL keep ireq_addr stable from ireq_valid rising until the cycle iresp_data_ok=1.
REQ-017 SHALL, in FETCH with iresp_data_ok=1 and (fd_valid=0 or stall=0), load fd_* with {1, iresp_data, pc}, set pc<=pc+4 (64-bit wrap), and stay in FETCH.
REQ-018 SHALL, in FETCH with iresp_data_ok=1, fd_valid=1 and stall=1, capture the word and pc in a one-entry buffer, set pc<=pc+4, and go to HOLD.
REQ-019 SHALL, in HOLD with stall=0, move the buffer into fd_* and return to FETCH.
REQ-020 SHALL clear fd_valid when stall=0 and no new instruction is loaded that cycle.
REQ-021 SHALL hold fd_* unchanged while stall=1 and fd_valid=1.
REQ-022 SHALL give redirect_valid top priority: next cycle fd_valid=0, buffer invalid, regardless of stall.
REQ-023 SHALL, on redirect in FETCH without iresp_data_ok, save redirect_pc and go to FLUSH.
REQ-024 SHALL, on redirect coinciding with iresp_data_ok, or in HOLD, discard the word, set pc<=redirect_pc, and go to FETCH.
REQ-025 SHALL, in FLUSH, discard the response on iresp_data_ok, set pc<=saved target, and go to FETCH; a further redirect in FLUSH overwrites the saved target.
REQ-026 SHALL have latency of one cycle from iresp_data_ok to fd_valid when not stalled.

Reset
REQ-027 SHALL, while reset=0, force state=FETCH, pc=PCINIT, fd_valid=0, fd_raw_instr=0, fd_pc=0, buffer invalid, and saved target=0.
REQ-028 SHALL assert ireq_valid=1 with ireq_addr=PCINIT in the first cycle after reset deasserts.
REQ-029 SHALL, if reset asserts mid-request, abandon that request; no late response is accepted.

Configuration
REQ-030 SHALL, with macro FETCH_MISALIGN_EN defined, add output fd_misalign (out, 1) and behave as follows when pc[1:0]!=0:
- no bus request is issued;
- fd_* is loaded with {1, 32'h0, pc} and fd_misalign=1;
- fetch halts until the next redirect.
REQ-031 SHALL, without FETCH_MISALIGN_EN, have no fd_misalign port and drive ireq_addr = {pc[63:2], 2'b00}.

Verification
REQ-032 SHALL cover reset release: ireq_addr=0x80000000 and data_ok with 0x00100093 next cycle -> fd_valid=1, fd_raw_instr=0x00100093, fd_pc=0x80000000; next ireq_addr=0x80000004.
REQ-033 SHALL cover stall: stall=1 with fd_valid=1 and data_ok(0x00208133) -> HOLD, ireq_valid=0, fd_* unchanged; stall=0 -> fd_raw_instr=0x00208133, fd_pc=0x80000004.
REQ-034 SHALL cover redirect while waiting: redirect_pc=0x80000100 two cycles before data_ok -> response discarded, fd_valid=0, next ireq_addr=0x80000100.
REQ-035 SHALL cover redirect coinciding with data_ok: word dropped; next-cycle ireq_addr=redirect_pc and fd_valid=0.
REQ-036 SHALL cover asynchronous reset asserted between clock edges mid-request: outputs reach reset values immediately, and the later request restarts at PCINIT.
REQ-037 SHALL cover FETCH_MISALIGN_EN: redirect_pc=0x80000102 -> no request, fd_misalign=1, fd_pc=0x80000102.
